// File: rtl/frame_buffer_banked.sv
// Banked pixel framebuffer: masked fragment port, full-frame memset and AXIS commit.
// Optional same-cycle read/write forwarding is enabled by FRAME_BUFFER_RW_FORWARD_EN.
module frame_buffer_banked #(
   parameter int FRAME_SIZE   = 16384,
   parameter int PIXEL_WIDTH  = 16,
   parameter int STREAM_WIDTH = 16,
   parameter int MASK_WIDTH   = 4,
   parameter int INDEX_WIDTH  = $clog2(FRAME_SIZE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [INDEX_WIDTH-1:0]  fragIndexRead,
   output logic [PIXEL_WIDTH-1:0]  fragOut,
   input  logic [INDEX_WIDTH-1:0]  fragIndexWrite,
   input  logic [PIXEL_WIDTH-1:0]  fragIn,
   input  logic                    fragWriteEnable,
   input  logic [MASK_WIDTH-1:0]   fragMask,
   input  logic                    apply,
   output logic                    applied,
   input  logic                    cmdCommit,
   input  logic                    cmdMemset,
   input  logic [PIXEL_WIDTH-1:0]  clearColor,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [STREAM_WIDTH-1:0] m_axis_tdata
);

   localparam int PPB   = STREAM_WIDTH / PIXEL_WIDTH;
   localparam int CH    = PIXEL_WIDTH / MASK_WIDTH;
   localparam int DEPTH = FRAME_SIZE / PPB;
   localparam int WW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW    = (PPB > 1) ? $clog2(PPB) : 1;
   localparam logic [WW-1:0] LAST = WW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, MEMSET, COMMIT} state_t;

   state_t state, state_next;

   logic [CH-1:0] mem [PPB][MASK_WIDTH][DEPTH];

   logic [BW-1:0]           rd_bank, wr_bank;
   logic [WW-1:0]           rd_word, wr_word;
   logic [PIXEL_WIDTH-1:0]  frag_rd;
   logic                    frag_we, start;
   logic [WW-1:0]           cnt;
   logic                    issuing, issue;
   logic [PIXEL_WIDTH-1:0]  clr_color;
   logic                    clr_mode, clr_hit;
   logic                    rd_valid, rd_last;
   logic [WW-1:0]           rd_word_q;
   logic [STREAM_WIDTH-1:0] rd_data;
   logic [STREAM_WIDTH-1:0] ent [2];
   logic [1:0]              ent_last;
   logic                    wptr, rptr;
   logic [1:0]              fcnt;
   logic [2:0]              occ;
   logic                    push, pop;

   assign rd_bank = BW'(fragIndexRead % PPB);
   assign rd_word = WW'(fragIndexRead / PPB);
   assign wr_bank = BW'(fragIndexWrite % PPB);
   assign wr_word = WW'(fragIndexWrite / PPB);

   assign frag_we = (state == IDLE) && fragWriteEnable;
   assign start   = (state == IDLE) && apply && (cmdCommit || cmdMemset);
   assign clr_hit = rd_valid && clr_mode;

   assign push = rd_valid;
   assign pop  = m_axis_tvalid && m_axis_tready;
   assign occ  = {1'b0, fcnt} + {2'b0, rd_valid};
   assign issue = (state == COMMIT) && issuing && ((occ < 3'd2) || pop);

   assign m_axis_tvalid = (fcnt != 2'd0);
   assign m_axis_tdata  = ent[rptr];
   assign m_axis_tlast  = m_axis_tvalid && ent_last[rptr];

   // Fragment read data, optionally merged with a same-cycle write.
   always_comb begin
      frag_rd = '0;
      for (int c = 0; c < MASK_WIDTH; c++) begin
         frag_rd[c*CH +: CH] = mem[rd_bank][c][rd_word];
`ifdef FRAME_BUFFER_RW_FORWARD_EN
         if (fragWriteEnable && fragMask[c] &&
             (fragIndexRead == fragIndexWrite))
            frag_rd[c*CH +: CH] = fragIn[c*CH +: CH];
`endif
      end
   end

   // Storage write port: memset, clear-behind, or masked fragment write.
   always_ff @(posedge clk) begin
      for (int b = 0; b < PPB; b++) begin
         for (int c = 0; c < MASK_WIDTH; c++) begin
            if (state == MEMSET)
               mem[b][c][cnt] <= clr_color[c*CH +: CH];
            else if (clr_hit)
               mem[b][c][rd_word_q] <= clr_color[c*CH +: CH];
            else if (frag_we && (wr_bank == BW'(b)) && fragMask[c])
               mem[b][c][wr_word] <= fragIn[c*CH +: CH];
         end
      end
   end

   // Fragment read register; holds while a command is running.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         fragOut <= '0;
      else if (state == IDLE)
         fragOut <= frag_rd;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:
            if (start)
               state_next = cmdCommit ? COMMIT : MEMSET;
         MEMSET:
            if (cnt == LAST)
               state_next = IDLE;
         COMMIT:
            if (pop && m_axis_tlast)
               state_next = IDLE;
         default:
            state_next = IDLE;
      endcase
   end

   // Status output: idle means the last command is done.
   always_comb begin
      applied = (state == IDLE);
   end

   // Command latch and shared word counter for memset and commit reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         issuing   <= 1'b0;
         clr_color <= '0;
         clr_mode  <= 1'b0;
      end else if (start) begin
         cnt       <= '0;
         issuing   <= cmdCommit;
         clr_color <= clearColor;
         clr_mode  <= cmdCommit && cmdMemset;
      end else if ((state == MEMSET) || issue) begin
         cnt <= (cnt == LAST) ? '0 : cnt + WW'(1);
         if (issue && (cnt == LAST))
            issuing <= 1'b0;
      end
   end

   // Commit read stage: one word across all banks per issued read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_word_q <= '0;
         rd_data   <= '0;
      end else begin
         rd_valid <= issue;
         if (issue) begin
            rd_last   <= (cnt == LAST);
            rd_word_q <= cnt;
            for (int b = 0; b < PPB; b++)
               for (int c = 0; c < MASK_WIDTH; c++)
                  rd_data[b*PIXEL_WIDTH + c*CH +: CH] <= mem[b][c][cnt];
         end
      end
   end

   // Two-entry skid buffer between the read stage and the stream port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent[0]   <= '0;
         ent[1]   <= '0;
         ent_last <= '0;
         wptr     <= 1'b0;
         rptr     <= 1'b0;
         fcnt     <= 2'd0;
      end else begin
         if (push) begin
            ent[wptr]      <= rd_data;
            ent_last[wptr] <= rd_last;
            wptr           <= ~wptr;
         end
         if (pop)
            rptr <= ~rptr;
         fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: doc/frame_buffer_banked.md
Name: frame_buffer_banked

Overview:
- Parametrised successor to the on-chip colour/depth framebuffer: single-pixel fragment read/write port, channel-masked writes, full-frame memset and AXIS commit.
- Generalised in pixel width, stream width (multiple pixels per beat) and channel count.
- Adds a combined commit+clear mode that clears each word as it is streamed out.
- Sits between the fragment pipeline and the display/DMA stream; one instance per colour and per depth buffer.

Parameters:
- FRAME_SIZE, 16384: pixels per frame; must be a multiple of PPB.
- PIXEL_WIDTH, 16: bits per pixel.
- STREAM_WIDTH, 16: AXIS data width; a multiple of PIXEL_WIDTH. PPB = STREAM_WIDTH/PIXEL_WIDTH.
- MASK_WIDTH, 4: write-mask channels per pixel; PIXEL_WIDTH divisible by MASK_WIDTH. CH = PIXEL_WIDTH/MASK_WIDTH.
- INDEX_WIDTH, $clog2(FRAME_SIZE): fragment index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fragIndexRead  in  INDEX_WIDTH  fragment read address
- fragOut  out  PIXEL_WIDTH  read data, 1-cycle latency
- fragIndexWrite  in  INDEX_WIDTH  fragment write address
- fragIn  in  PIXEL_WIDTH  write data
- fragWriteEnable  in  1  write strobe
- fragMask  in  MASK_WIDTH  per-channel write enable; bit i covers fragIn[i*CH +: CH], MSB = top channel
- apply  in  1  start command (sampled in IDLE only)
- applied  out  1  high = idle/command done
- cmdCommit  in  1  stream frame out
- cmdMemset  in  1  fill frame with clearColor
- clearColor  in  PIXEL_WIDTH  fill value, latched at apply
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready
- m_axis_tlast  out  1  last beat of frame
- m_axis_tdata  out  STREAM_WIDTH  pixel 0 of a beat in the LSBs

Behaviour:
- Storage: PPB banks × MASK_WIDTH channel slices, each FRAME_SIZE/PPB deep. Bank = index % PPB, word = index / PPB. Masked writes use per-slice write enables, with no read-modify-write.
- Reset values: applied=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fragOut=0, FSM=IDLE. Memory contents are not cleared by reset.
- Fragment port:
  - Active only in IDLE. In IDLE, a write takes effect at the clock edge and is visible to a read issued the following cycle.
  - While busy, writes are dropped and fragOut holds its last value.
- FSM states: IDLE, MEMSET, COMMIT.
  - IDLE: apply && (cmdCommit || cmdMemset) → latch cmds and clearColor, clear word counter, applied←0. Next state is COMMIT if cmdCommit, else MEMSET.
  - apply with neither cmd is a no-op; applied stays 1.
  - apply outside IDLE is ignored.
- MEMSET:
  - Writes clearColor to all banks and all channels of one word per cycle, ignoring fragMask.
  - After word FRAME_SIZE/PPB−1 → IDLE with applied←1.
  - Total: FRAME_SIZE/PPB cycles.
- COMMIT:
  - Memory read latency is 1 cycle; a 2-entry skid buffer decouples tready. First tvalid rises 2 cycles after apply is sampled.
  - tdata is stable while tvalid && !tready.
  - tlast=1 only on beat FRAME_SIZE/PPB−1.
  - With full tready, one beat per cycle is sustained.
  - If cmdMemset was also latched: each word is overwritten with clearColor the cycle after it is read (clear-behind). No separate MEMSET pass follows.
  - After the tlast handshake → IDLE; applied←1 on the next cycle.
- Word counter wraps to 0 on completion; it never exceeds the last word.
- Reset mid-operation: immediate return to IDLE, tvalid drops, applied=1. Partially cleared memory is left as-is.

Optional Feature:
- FRAME_BUFFER_RW_FORWARD_EN
- Defined: if fragWriteEnable && fragIndexRead==fragIndexWrite in the same IDLE cycle, the next cycle's fragOut returns the merged value: masked channels from fragIn, unmasked channels from memory.
- Undefined: same-cycle read returns the pre-write memory value.

Test Plan:
- PIXEL_WIDTH=16, STREAM_WIDTH=32, FRAME_SIZE=16. Memset clearColor=0xF00F, then commit with tready=1 → 8 beats of 0xF00FF00F; tlast on beat 7; applied low from the cycle after apply until 1 cycle after the last handshake.
- Write index 5 = 0x1234 with mask 4'b1111, then index 5 = 0xABCD with mask 4'b1010 → read of index 5 = 0xA2C4. Commit beat 2 = {0xA2C4, pixel 4}.
- Commit+memset with clearColor=0: first commit returns prior data; a second commit returns all zeros.
- tready toggled 1,0,0,1 during commit → no beat lost or duplicated; tdata held while stalled; 8 beats total.
- Fragment write to index 3 during MEMSET → dropped; index 3 = clearColor afterwards. apply asserted again mid-COMMIT → ignored.
- reset asserted at beat 4 of commit → tvalid=0 and applied=1 immediately. A new commit then streams from beat 0. Also cover the RW-forward read at 0x1234 both with and without FRAME_BUFFER_RW_FORWARD_EN.
